input_handshake_unit: RTL and testbench

Implements the user-side end of the CPU IN-instruction protocol. While the control unit requests input, the block stalls the processor and waits for a debounced press of the enter key. It then samples the switches, presents the value to the datapath, and releases the stall for exactly one cycle. It sits between the board switches/key and the CPU core, feeding the input-signal mux and the PC hold logic.

---
 rtl/input_handshake_unit_pkg.sv | 5 +
 rtl/input_handshake_unit_button_debouncer.sv | 38 +++
 rtl/input_handshake_unit.sv | 59 +++++
 tb/tb_input_handshake_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/input_handshake_unit_pkg.sv
// input_handshake_unit_pkg: FSM state encoding and default debounce length.
package input_handshake_unit_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_RELEASE, WAIT_PRESS, CAPTURE} state_e;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
endpackage

// File: rtl/input_handshake_unit_button_debouncer.sv
// button_debouncer: synchronizes the active-low enter key and filters bounce into a clean pressed level.
module button_debouncer
  import input_handshake_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  output logic pressed
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic deb_q, deb_d, press_raw, differ;
  assign press_raw = ~sync_q[SYNC_STAGES-1];
  assign differ    = press_raw != deb_q;
  assign pressed   = deb_q;
  // the level only flips once the raw key has disagreed with it for DEBOUNCE_CYCLES straight cycles
  always_comb begin
    cnt_d = (differ && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
    deb_d = (differ && cnt_q == LAST) ? ~deb_q : deb_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q[0] <= button_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end
endmodule

// File: rtl/input_handshake_unit.sv
// input_handshake_unit: stalls the CPU during IN until a fresh debounced key press, then presents the switch value for one cycle.
module input_handshake_unit
  import input_handshake_unit_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] switches,
  input  logic                  button_n,
  input  logic                  in_request,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_valid,
  output logic                  waiting_led
);
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] sw_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] in_data_q, in_data_d;
  logic pressed;
  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_debouncer (
    .clock   (clock),
    .reset   (reset),
    .button_n(button_n),
    .pressed (pressed)
  );
  // a key still held from the previous capture must be released before it can count again
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         state_d = in_request ? WAIT_RELEASE : IDLE;
      WAIT_RELEASE: state_d = !in_request ? IDLE : (!pressed ? WAIT_PRESS : WAIT_RELEASE);
      WAIT_PRESS:   state_d = !in_request ? IDLE : (pressed ? CAPTURE : WAIT_PRESS);
      default:      state_d = IDLE;
    endcase
    in_data_d = (state_d == CAPTURE) ? sw_q[SYNC_STAGES-1] : in_data_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      in_data_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sw_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      in_data_q <= in_data_d;
      sw_q[0]   <= switches;
      for (int i = 1; i < SYNC_STAGES; i++) sw_q[i] <= sw_q[i-1];
    end
  end
  assign stall       = in_request & (state_q != CAPTURE);
  assign in_valid    = state_q == CAPTURE;
  assign waiting_led = (state_q == WAIT_RELEASE) || (state_q == WAIT_PRESS);
  assign in_data     = in_data_q;
endmodule

// File: tb/tb_input_handshake_unit.sv
// tb_input_handshake_unit: directed plan plus random traffic, checked every cycle against a behavioural model.
module tb_input_handshake_unit;
  localparam int DW = 16;
  localparam int D  = 4;
  localparam int S  = 2;
  localparam int M_IDLE = 0, M_WREL = 1, M_WPRESS = 2, M_CAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DW-1:0] switches = '0;
  logic button_n = 1'b1;
  logic in_request = 1'b0;
  logic stall, in_valid, waiting_led;
  logic [DW-1:0] in_data;

  int checks = 0;
  int passes = 0;
  bit started = 0;

  input_handshake_unit #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clock      (clk),
    .reset      (rst),
    .switches   (switches),
    .button_n   (button_n),
    .in_request (in_request),
    .stall      (stall),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .waiting_led(waiting_led)
  );

  always #5 clk = ~clk;

  // model: inputs reach the logic S edges late; the key level flips after D consecutive disagreeing samples
  bit bn_line[$];
  logic [DW-1:0] sw_line[$];
  bit pr_win[$];
  bit m_deb;
  int m_mode;
  logic [DW-1:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bn_line = {};
      sw_line = {};
      for (int i = 0; i < S; i++) begin
        bn_line.push_back(1'b1);
        sw_line.push_back('0);
      end
      pr_win.delete();
      m_deb  = 0;
      m_mode = M_IDLE;
      m_data = '0;
    end else begin
      automatic bit pr = !bn_line[0];
      automatic bit old_deb = m_deb;
      automatic logic [DW-1:0] sw_s = sw_line[0];
      automatic bit all_diff = 1;
      pr_win.push_back(pr);
      if (pr_win.size() > D) void'(pr_win.pop_front());
      foreach (pr_win[k]) if (pr_win[k] == m_deb) all_diff = 0;
      if (pr_win.size() == D && all_diff) begin
        m_deb = !m_deb;
        pr_win.delete();
      end
      case (m_mode)
        M_IDLE:   if (in_request) m_mode = M_WREL;
        M_WREL:   if (!in_request) m_mode = M_IDLE; else if (!old_deb) m_mode = M_WPRESS;
        M_WPRESS: if (!in_request) m_mode = M_IDLE;
                  else if (old_deb) begin m_mode = M_CAP; m_data = sw_s; end
        default:  m_mode = M_IDLE;
      endcase
      void'(bn_line.pop_front());
      bn_line.push_back(button_n);
      void'(sw_line.pop_front());
      sw_line.push_back(switches);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("stall", 32'(stall), 32'(in_request && m_mode != M_CAP));
      chk("in_valid", 32'(in_valid), 32'(m_mode == M_CAP));
      chk("waiting_led", 32'(waiting_led), 32'(m_mode == M_WREL || m_mode == M_WPRESS));
      chk("in_data", 32'(in_data), 32'(m_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n, output bit seen_valid);
    seen_valid = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (in_valid) seen_valid = 1;
    end
  endtask

  task automatic press_and_count(output int n, output logic [DW-1:0] d, output logic s);
    button_n = 1'b0;
    n = 0;
    d = '0;
    s = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (in_valid && n == 0) begin
        n = i;
        d = in_data;
        s = stall;
      end
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] d;
    logic s;
    bit seen;
    int run;
    #1 rst = 1'b1;
    // 1: reset values
    repeat (2) step();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_valid", 32'(in_valid), 0);
    chk("rst_data", 32'(in_data), 0);
    chk("rst_led", 32'(waiting_led), 0);
    rst = 1'b0;
    started = 1;
    steps(2, seen);
    chk("post_rst_data", 32'(in_data), 0);
    chk("post_rst_led", 32'(waiting_led), 0);
    // 2: basic capture
    switches = 16'h00A5;
    in_request = 1'b1;
    #1 chk("t2_stall_now", 32'(stall), 1);
    step();
    chk("t2_led", 32'(waiting_led), 1);
    steps(3, seen);
    press_and_count(n, d, s);
    chk("t2_latency", 32'(n), 7);
    chk("t2_data", 32'(d), 32'h00A5);
    chk("t2_stall_cap", 32'(s), 0);
    // 3: bouncing key never debounces
    button_n = 1'b1;
    steps(8, seen);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      button_n = (i % 4) >= 2;
      step();
      if (in_valid) seen = 1;
    end
    chk("t3_no_valid", 32'(seen), 0);
    chk("t3_stall", 32'(stall), 1);
    chk("t3_data", 32'(in_data), 32'h00A5);
    // 4: key already held when the request arrives
    in_request = 1'b0;
    step();
    button_n = 1'b0;
    steps(10, seen);
    in_request = 1'b1;
    steps(10, seen);
    chk("t4_no_valid", 32'(seen), 0);
    chk("t4_led", 32'(waiting_led), 1);
    button_n = 1'b1;
    steps(8, seen);
    press_and_count(n, d, s);
    chk("t4_latency", 32'(n), 7);
    chk("t4_data", 32'(d), 32'h00A5);
    // 5: back-to-back request needs a fresh release and press
    switches = 16'h1234;
    steps(10, seen);
    chk("t5_no_valid", 32'(seen), 0);
    chk("t5_data_hold", 32'(in_data), 32'h00A5);
    button_n = 1'b1;
    steps(8, seen);
    press_and_count(n, d, s);
    chk("t5_latency", 32'(n), 7);
    chk("t5_data", 32'(d), 32'h1234);
    // 6: asynchronous reset pulse while waiting for the press
    button_n = 1'b1;
    steps(8, seen);
    chk("t6_led_before", 32'(waiting_led), 1);
    rst = 1'b1;
    #1;
    chk("t6_data_rst", 32'(in_data), 0);
    chk("t6_led_rst", 32'(waiting_led), 0);
    chk("t6_stall_rst", 32'(stall), 1);
    #1 rst = 1'b0;
    steps(4, seen);
    press_and_count(n, d, s);
    chk("t6_latency", 32'(n), 7);
    chk("t6_data", 32'(d), 32'h1234);
    // random traffic against the model
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        button_n = 1'($urandom_range(1, 0));
        run = $urandom_range(9, 1);
      end
      run--;
      if ($urandom_range(39, 0) == 0) in_request = !in_request;
      switches = 16'($urandom);
      step();
    end
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
